slot_allocator: RTL

- Free-slot allocator built around the ffs priority encoder.
- Holds a bitmap of free slots (1 = free).
- Hands out the lowest free index to a consumer over a valid/ready handshake, and takes released indices back on a free port (index-to-one-hot decode, the reverse direction of ffs).
- Used by packet/flow buffers that need buffer-slot IDs.

---
 rtl/slot_allocator_if.sv | 23 ++
 rtl/slot_allocator.sv | 63 ++++++
 2 files changed

// File: rtl/slot_allocator_if.sv
// Allocate/release port bundle for slot_allocator; master is the allocator side.
// Latency and backpressure are defined by the allocator: a registered stage toward the consumer, and no backpressure on the free port.
interface slot_allocator_if #(
    parameter int WIDTH_LOG = 4
);
    logic                 alloc_valid;
    logic [WIDTH_LOG-1:0] alloc_idx;
    logic                 alloc_ready;
    logic                 free_valid;
    logic [WIDTH_LOG-1:0] free_idx;
    logic [WIDTH_LOG:0]   free_count;
    logic                 err_double_free;

    modport master (
        output alloc_valid, alloc_idx, free_count, err_double_free,
        input  alloc_ready, free_valid, free_idx
    );

    modport slave (
        input  alloc_valid, alloc_idx, free_count, err_double_free,
        output alloc_ready, free_valid, free_idx
    );
endinterface

// File: rtl/slot_allocator.sv
// Lowest-free-index slot allocator: a registered offer stage refilled from a free bitmap, with releases returned through a one-hot decode.
// A freed slot becomes offerable 2 cycles after release when the allocator is empty; alloc holds under !ready, and the free port never stalls.
module slot_allocator #(
    parameter int WIDTH_LOG = 4
) (
    input  logic               clk,
    input  logic               rst,
    slot_allocator_if.master   bus
);
    localparam int WIDTH = 2 ** WIDTH_LOG;

    logic [WIDTH-1:0]     free_map;
    logic [WIDTH-1:0]     free_map_nxt;
    logic [WIDTH_LOG-1:0] ffs_idx;
    logic                 refill;
    logic                 take;
    logic                 release_ok;
    logic [WIDTH-1:0]     refill_clr;
    logic [WIDTH-1:0]     release_set;

    always_comb begin
        ffs_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (free_map[i]) ffs_idx = WIDTH_LOG'(i);
        end
    end

    assign take   = bus.alloc_valid && bus.alloc_ready;
    assign refill = !bus.alloc_valid || bus.alloc_ready;

    // A staged slot is owned by nobody yet, so releasing it counts as a double free.
    assign release_ok = bus.free_valid && !free_map[bus.free_idx] &&
                        !(bus.alloc_valid && (bus.alloc_idx == bus.free_idx));

    always_comb begin
        refill_clr  = '0;
        release_set = '0;
        if (refill && (free_map != '0)) refill_clr[ffs_idx] = 1'b1;
        if (release_ok) release_set[bus.free_idx] = 1'b1;
        free_map_nxt = (free_map & ~refill_clr) | release_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_map            <= '1;
            bus.alloc_valid     <= 1'b0;
            bus.alloc_idx       <= '0;
            bus.free_count      <= (WIDTH_LOG + 1)'(WIDTH);
            bus.err_double_free <= 1'b0;
        end else begin
            free_map            <= free_map_nxt;
            bus.err_double_free <= bus.free_valid && !release_ok;
            if (refill) begin
                bus.alloc_valid <= (free_map != '0);
                if (free_map != '0) bus.alloc_idx <= ffs_idx;
            end
            if (release_ok && !take)
                bus.free_count <= bus.free_count + 1'b1;
            else if (take && !release_ok)
                bus.free_count <= bus.free_count - 1'b1;
        end
    end
endmodule
